// File: rtl/iter_alu_if.sv
// Request/response bundle for iter_alu: operand handshake in, result handshake out.
// Handshake rule: a transfer happens on a rising clk edge where valid && ready are both 1;
// the sender holds its payload stable while valid is high and ready is low.
interface iter_alu_if #(
  parameter int xlen = 64
) ();
  logic            in_valid;
  logic            in_ready;
  logic [xlen-1:0] a;
  logic [xlen-1:0] b;
  logic [3:0]      alu_op;
  logic            out_valid;
  logic            out_ready;
  logic [xlen-1:0] result;
  logic            zero;

  // Requester side (testbench or upstream pipeline)
  modport master (
    output in_valid, a, b, alu_op, out_ready,
    input  in_ready, out_valid, result, zero
  );

  // ALU side
  modport slave (
    input  in_valid, a, b, alu_op, out_ready,
    output in_ready, out_valid, result, zero
  );
endinterface

// File: rtl/iter_alu.sv
// Iterative ALU: single-cycle logic/arith/shift ops plus multi-cycle
// shift-add multiply and restoring divide sharing one hi/lo register pair.
// state_o exposes the FSM state (0 IDLE, 1 BUSY, 2 DONE) for observation.
module iter_alu #(
  parameter int xlen = 64
) (
  input  logic         clk,
  input  logic         rst,
  iter_alu_if.slave    bus,
  output logic [1:0]   state_o
);

  localparam int SHW = $clog2(xlen);
  localparam int CW  = SHW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q;
  logic [3:0]      op_q;
  logic [xlen-1:0] a_q;
  logic [xlen-1:0] b_q;
  logic [xlen-1:0] hi_q;
  logic [xlen-1:0] lo_q;
  logic [CW-1:0]   cnt_q;
  logic [xlen-1:0] result_q;
  logic            zero_q;

  logic            accept;
  logic            is_iter;
  logic [xlen-1:0] alu_res;
  logic [SHW-1:0]  shamt;
  logic [xlen:0]   sub_w;

  logic [xlen:0]   mul_sum;
  logic [xlen-1:0] mul_hi_d;
  logic [xlen-1:0] mul_lo_d;
  logic [xlen:0]   rem_sh;
  logic [xlen:0]   trial;
  logic            div_ge;
  logic [xlen-1:0] div_hi_d;
  logic [xlen-1:0] div_lo_d;
  logic [xlen-1:0] step_hi_d;
  logic [xlen-1:0] step_lo_d;
  logic [xlen-1:0] iter_res_d;

  assign accept  = bus.in_valid && (state_q == IDLE);
  assign is_iter = bus.alu_op inside {4'b1010, 4'b1011, 4'b1100, 4'b1101};
  assign shamt   = bus.b[SHW-1:0];
  assign sub_w   = {1'b0, bus.a} - {1'b0, bus.b};

  // Single-cycle operations, evaluated directly on the incoming operands
  always_comb begin
    alu_res = '0;
    unique case (bus.alu_op)
      4'b0000: alu_res = bus.a & bus.b;
      4'b0001: alu_res = bus.a | bus.b;
      4'b0010: alu_res = bus.a + bus.b;
      4'b0110: alu_res = sub_w[xlen-1:0];
      4'b0111: alu_res = {{(xlen-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      4'b0011: alu_res = {{(xlen-1){1'b0}}, sub_w[xlen]};
      4'b0100: alu_res = bus.a ^ bus.b;
      4'b0101: alu_res = bus.a << shamt;
      4'b1000: alu_res = bus.a >> shamt;
      4'b1001: alu_res = $unsigned($signed(bus.a) >>> shamt);
      default: alu_res = '0;
    endcase
  end

  // One iteration step for multiply (hi:lo shifts right) and divide (rem:quo shifts left)
  always_comb begin
    // Multiply: lo holds remaining multiplier bits, hi accumulates with carry into bit xlen
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
    mul_hi_d = mul_sum[xlen:1];
    mul_lo_d = {mul_sum[0], lo_q[xlen-1:1]};
    // Restoring divide: hi is the partial remainder, lo shifts dividend out and quotient in.
    // With a zero divisor every trial succeeds, giving all-ones quotient and remainder = a.
    rem_sh   = {hi_q, lo_q[xlen-1]};
    div_ge   = (rem_sh >= {1'b0, b_q});
    trial    = rem_sh - {1'b0, b_q};
    div_hi_d = div_ge ? trial[xlen-1:0] : rem_sh[xlen-1:0];
    div_lo_d = {lo_q[xlen-2:0], div_ge};
    // op bit 2 separates divide (110x) from multiply (101x); bit 0 picks the high half
    step_hi_d  = op_q[2] ? div_hi_d : mul_hi_d;
    step_lo_d  = op_q[2] ? div_lo_d : mul_lo_d;
    iter_res_d = op_q[0] ? step_hi_d : step_lo_d;
  end

  // Control FSM with registered result/zero, updated only on entry to DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            op_q  <= bus.alu_op;
            a_q   <= bus.a;
            b_q   <= bus.b;
            cnt_q <= '0;
            if (is_iter) begin
              hi_q    <= '0;
              // Multiply consumes b bit by bit; divide shifts a out from the top
              lo_q    <= bus.alu_op[2] ? bus.a : bus.b;
              state_q <= BUSY;
            end else begin
              result_q <= alu_res;
              zero_q   <= (alu_res == '0);
              state_q  <= DONE;
            end
          end
        end
        BUSY: begin
          hi_q  <= step_hi_d;
          lo_q  <= step_lo_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(xlen - 1)) begin
            result_q <= iter_res_d;
            zero_q   <= (iter_res_d == '0);
            state_q  <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_iter_alu.sv
// Directed testbench for iter_alu at xlen = 32.
module tb_iter_alu;

  logic       clk;
  logic       rst;
  logic [1:0] state_o;
  int         n_checks;
  int         n_fail;

  iter_alu_if #(.xlen(32)) bus ();

  iter_alu #(.xlen(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .state_o (state_o)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks (all called at posedge + #1) ----------------
  // Issue one request from IDLE, scramble operands after acceptance, wait for out_valid.
  task automatic run_op(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv,
                        output logic [31:0] res, output logic z, output int lat,
                        output int rdy_hits);
    bus.in_valid = 1'b1;
    bus.alu_op   = op;
    bus.a        = av;
    bus.b        = bv;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.a        = $urandom();
    bus.b        = $urandom();
    bus.alu_op   = 4'($urandom_range(0, 15));
    lat      = 1;
    rdy_hits = 0;
    while (!bus.out_valid && lat < 200) begin
      if (bus.in_ready) rdy_hits++;
      @(posedge clk); #1;
      lat++;
    end
    res = bus.result;
    z   = bus.zero;
  endtask

  task automatic release_result();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    bus.in_valid = 1'b1;
    bus.alu_op   = 4'b0010;
    bus.a        = 32'd1;
    bus.b        = 32'd1;
    do_reset();
    bus.in_valid = 1'b0;
    n_checks++;
    if (state_o !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", state_o); end
    n_checks++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    n_checks++;
    if (bus.result !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h want 0", bus.result); end
    n_checks++;
    if (bus.zero !== 1'b1) begin n_fail++; $display("FAIL reset_zero: got %b want 1", bus.zero); end
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    string       name;
  } vec_t;

  task automatic test_single_cycle();
    vec_t        v[12];
    logic [31:0] res;
    logic        z;
    int          lat;
    int          rh;
    v[0]  = '{4'b0010, 32'd7,        32'hFFFFFFFD, 32'd4,        "add_wrap"};
    v[1]  = '{4'b0110, 32'd5,        32'd5,        32'd0,        "sub_zero"};
    v[2]  = '{4'b0111, 32'hFFFFFFFF, 32'd1,        32'd1,        "slt_neg"};
    v[3]  = '{4'b0011, 32'hFFFFFFFF, 32'd1,        32'd0,        "sltu_big"};
    v[4]  = '{4'b1001, 32'h80000000, 32'd31,       32'hFFFFFFFF, "sra_31"};
    v[5]  = '{4'b0101, 32'd1,        32'h21,       32'd2,        "sll_mask"};
    v[6]  = '{4'b1000, 32'h80000000, 32'd4,        32'h08000000, "srl_4"};
    v[7]  = '{4'b0000, 32'hF0F0,     32'hFF00,     32'hF000,     "and"};
    v[8]  = '{4'b0001, 32'hF0F0,     32'h0F0F,     32'hFFFF,     "or"};
    v[9]  = '{4'b0100, 32'hFF,       32'h0F,       32'hF0,       "xor"};
    v[10] = '{4'b1110, 32'd5,        32'd5,        32'd0,        "op_1110"};
    v[11] = '{4'b0110, 32'd0,        32'd1,        32'hFFFFFFFF, "sub_wrap"};
    for (int i = 0; i < 12; i++) begin
      run_op(v[i].op, v[i].a, v[i].b, res, z, lat, rh);
      n_checks++;
      if (lat !== 1) begin n_fail++; $display("FAIL %s_latency: got %0d want 1", v[i].name, lat); end
      n_checks++;
      if (res !== v[i].exp) begin n_fail++; $display("FAIL %s_result: got %h want %h", v[i].name, res, v[i].exp); end
      n_checks++;
      if (z !== (v[i].exp == 32'h0)) begin n_fail++; $display("FAIL %s_zero: got %b want %b", v[i].name, z, (v[i].exp == 32'h0)); end
      release_result();
    end
  endtask

  task automatic test_iterative();
    vec_t        v[8];
    logic [31:0] res;
    logic        z;
    int          lat;
    int          rh;
    v[0] = '{4'b1010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        "mul_max"};
    v[1] = '{4'b1011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, "mulhu_max"};
    v[2] = '{4'b1010, 32'd1234,     32'd5678,     32'd7006652,  "mul_small"};
    v[3] = '{4'b1011, 32'h80000000, 32'd4,        32'd2,        "mulhu_pow2"};
    v[4] = '{4'b1100, 32'd100,      32'd7,        32'd14,       "divu"};
    v[5] = '{4'b1101, 32'd100,      32'd7,        32'd2,        "remu"};
    v[6] = '{4'b1100, 32'd5,        32'd0,        32'hFFFFFFFF, "divu_by0"};
    v[7] = '{4'b1101, 32'd5,        32'd0,        32'd5,        "remu_by0"};
    for (int i = 0; i < 8; i++) begin
      run_op(v[i].op, v[i].a, v[i].b, res, z, lat, rh);
      n_checks++;
      if (lat !== 33) begin n_fail++; $display("FAIL %s_latency: got %0d want 33", v[i].name, lat); end
      n_checks++;
      if (rh !== 0) begin n_fail++; $display("FAIL %s_in_ready_busy: got %0d cycles high want 0", v[i].name, rh); end
      n_checks++;
      if (res !== v[i].exp) begin n_fail++; $display("FAIL %s_result: got %h want %h", v[i].name, res, v[i].exp); end
      n_checks++;
      if (z !== (v[i].exp == 32'h0)) begin n_fail++; $display("FAIL %s_zero: got %b want %b", v[i].name, z, (v[i].exp == 32'h0)); end
      release_result();
    end
  endtask

  task automatic test_hold_in_done();
    logic [31:0] res;
    logic        z;
    int          lat;
    int          rh;
    run_op(4'b0010, 32'd1, 32'd1, res, z, lat, rh);
    n_checks++;
    if (res !== 32'd2) begin n_fail++; $display("FAIL hold_first_result: got %h want 2", res); end
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin
        bus.in_valid = 1'b1;
        bus.alu_op   = 4'b0010;
        bus.a        = 32'd100;
        bus.b        = 32'd100;
      end else begin
        bus.in_valid = 1'b0;
      end
      @(posedge clk); #1;
      n_checks++;
      if (bus.result !== 32'd2 || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_cycle%0d: got result=%h valid=%b ready=%b want 2/1/0", c, bus.result, bus.out_valid, bus.in_ready);
      end
    end
    // Request presented on the releasing edge must not be taken
    bus.in_valid = 1'b1;
    bus.a        = 32'd9;
    bus.b        = 32'd9;
    release_result();
    bus.in_valid = 1'b0;
    n_checks++;
    if (state_o !== 2'd0 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_release: got state=%0d ready=%b valid=%b want 0/1/0", state_o, bus.in_ready, bus.out_valid);
    end
    @(posedge clk); #1;
    n_checks++;
    if (state_o !== 2'd0 || bus.result !== 32'd2) begin
      n_fail++;
      $display("FAIL hold_idle_after: got state=%0d result=%h want 0/2", state_o, bus.result);
    end
  endtask

  task automatic test_reset_abort();
    int          seen;
    logic [31:0] res;
    logic        z;
    int          lat;
    int          rh;
    bus.in_valid = 1'b1;
    bus.alu_op   = 4'b1010;
    bus.a        = 32'hFFFFFFFF;
    bus.b        = 32'hFFFFFFFF;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.result !== 32'h0) begin
      n_fail++;
      $display("FAIL abort_state: got valid=%b ready=%b result=%h want 0/1/0", bus.out_valid, bus.in_ready, bus.result);
    end
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen++;
    end
    n_checks++;
    if (seen !== 0) begin n_fail++; $display("FAIL abort_no_result: got %0d valid cycles want 0", seen); end
    run_op(4'b0010, 32'd2, 32'd2, res, z, lat, rh);
    n_checks++;
    if (res !== 32'd4 || lat !== 1) begin
      n_fail++;
      $display("FAIL abort_then_add: got result=%h lat=%0d want 4/1", res, lat);
    end
    release_result();
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_q[$];
    logic [31:0] res;
    logic [31:0] exp;
    logic        z;
    int          lat;
    int          rh;
    exp_q.push_back(32'd30);
    exp_q.push_back(32'd3);
    exp_q.push_back(32'd12);
    run_op(4'b0010, 32'd10, 32'd20, res, z, lat, rh);
    exp = exp_q.pop_front();
    n_checks++;
    if (res !== exp) begin n_fail++; $display("FAIL b2b_add: got %h want %h", res, exp); end
    release_result();
    run_op(4'b1100, 32'd21, 32'd6, res, z, lat, rh);
    exp = exp_q.pop_front();
    n_checks++;
    if (res !== exp) begin n_fail++; $display("FAIL b2b_divu: got %h want %h", res, exp); end
    release_result();
    run_op(4'b1010, 32'd3, 32'd4, res, z, lat, rh);
    exp = exp_q.pop_front();
    n_checks++;
    if (res !== exp) begin n_fail++; $display("FAIL b2b_mul: got %h want %h", res, exp); end
    release_result();
  endtask

  // Main sequence and final report
  initial begin
    n_checks      = 0;
    n_fail        = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.alu_op    = '0;
    @(posedge clk); #1;
    test_reset();
    test_single_cycle();
    test_iterative();
    test_hold_in_done();
    test_reset_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
